// File: rtl/obstacle_alert_fsm.sv
// rtl/obstacle_alert_fsm.sv - N-channel debounced priority obstacle alert controller
// Optional build macro: ALERT_PULSE_EN (blink the warning output while in HOLD)
module obstacle_alert_fsm #(
   parameter int N_SENSORS    = 3,
   parameter int DEBOUNCE_CYC = 4,
   parameter int HOLD_CYC     = 16,
   parameter int PULSE_DIV    = 8,
   localparam int IDXW        = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic [N_SENSORS-1:0] sensor_i,
   output logic [N_SENSORS-1:0] warn_o,
   output logic [IDXW-1:0]      active_idx_o,
   output logic                 busy_o
);

   localparam int CNTW  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int HOLDW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

   // Reject parameter sets outside the supported range at elaboration
   if (N_SENSORS < 1 || N_SENSORS > 8 || DEBOUNCE_CYC < 1 || HOLD_CYC < 1 || PULSE_DIV < 1) begin : g_param_check
      $error("obstacle_alert_fsm: illegal parameter value");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ALERT = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   logic [N_SENSORS-1:0] sync1;
   logic [N_SENSORS-1:0] sync2;
   logic [N_SENSORS-1:0] filtered;
   logic [CNTW-1:0]      deb_cnt [N_SENSORS];

   logic                 any;
   logic [IDXW-1:0]      pri_idx;

   state_t               state, state_d;
   logic [IDXW-1:0]      idx, idx_d;
   logic [HOLDW-1:0]     hold_cnt, hold_d;
   logic [N_SENSORS-1:0] warn_q, warn_d;
   logic                 busy_q;

   // Synchronise raw flags and debounce each channel independently
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1    <= '0;
         sync2    <= '0;
         filtered <= '0;
         for (int i = 0; i < N_SENSORS; i++) deb_cnt[i] <= '0;
      end else if (ena) begin
         sync1 <= sensor_i;
         sync2 <= sync1;
         for (int i = 0; i < N_SENSORS; i++) begin
            if (sync2[i] == filtered[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == CNTW'(DEBOUNCE_CYC - 1)) begin
               filtered[i] <= sync2[i];
               deb_cnt[i]  <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Lowest active index wins; scan downward so the last hit is the lowest
   always_comb begin
      any     = |filtered;
      pri_idx = '0;
      for (int i = N_SENSORS - 1; i >= 0; i--) begin
         if (filtered[i]) pri_idx = IDXW'(i);
      end
   end

   // Next-state logic: entry, pre-emption, hold countdown and re-arm
   always_comb begin
      state_d = state;
      idx_d   = idx;
      hold_d  = hold_cnt;
      case (state)
         S_IDLE: begin
            if (any) begin
               state_d = S_ALERT;
               idx_d   = pri_idx;
            end
         end
         S_ALERT: begin
            if (!filtered[idx]) begin
               if (any) begin
                  idx_d = pri_idx;
               end else begin
                  state_d = S_HOLD;
                  hold_d  = HOLDW'(HOLD_CYC - 1);
               end
            end else if (pri_idx < idx) begin
               idx_d = pri_idx;
            end
         end
         S_HOLD: begin
            if (any) begin
               state_d = S_ALERT;
               idx_d   = pri_idx;
            end else if (hold_cnt == '0) begin
               state_d = S_IDLE;
               idx_d   = '0;
            end else begin
               hold_d = hold_cnt - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
   end

`ifdef ALERT_PULSE_EN
   localparam int PW = (PULSE_DIV > 1) ? $clog2(PULSE_DIV) : 1;

   logic [PW-1:0] pulse_cnt, pulse_cnt_d;
   logic          pulse_on, pulse_on_d;

   // Blink phase: restart "on" at HOLD entry, toggle every PULSE_DIV held cycles
   always_comb begin
      pulse_cnt_d = pulse_cnt;
      pulse_on_d  = pulse_on;
      if (state_d == S_HOLD && state != S_HOLD) begin
         pulse_cnt_d = '0;
         pulse_on_d  = 1'b1;
      end else if (state_d == S_HOLD) begin
         if (pulse_cnt == PW'(PULSE_DIV - 1)) begin
            pulse_cnt_d = '0;
            pulse_on_d  = ~pulse_on;
         end else begin
            pulse_cnt_d = pulse_cnt + 1'b1;
         end
      end
   end

   // Blink phase register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pulse_cnt <= '0;
         pulse_on  <= 1'b0;
      end else if (ena) begin
         pulse_cnt <= pulse_cnt_d;
         pulse_on  <= pulse_on_d;
      end
   end

   // Warning drive: steady in ALERT, blinking in HOLD
   always_comb begin
      warn_d = '0;
      if (state_d == S_ALERT || (state_d == S_HOLD && pulse_on_d))
         warn_d = N_SENSORS'(1) << idx_d;
   end
`else
   // Warning drive: steady one-hot through ALERT and HOLD
   always_comb begin
      warn_d = '0;
      if (state_d != S_IDLE)
         warn_d = N_SENSORS'(1) << idx_d;
   end
`endif

   // State and registered outputs; ena low freezes everything except reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         idx      <= '0;
         hold_cnt <= '0;
         warn_q   <= '0;
         busy_q   <= 1'b0;
      end else if (ena) begin
         state    <= state_d;
         idx      <= idx_d;
         hold_cnt <= hold_d;
         warn_q   <= warn_d;
         busy_q   <= (state_d != S_IDLE);
      end
   end

   assign warn_o       = warn_q;
   assign active_idx_o = idx;
   assign busy_o       = busy_q;

endmodule
